// File: rtl/sram_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_fifo_rd_ctrl
// Description : Burst read controller for an sram_fifo. Pops at most one word
//               every two cycles so the fifo can refill its head from SRAM,
//               buffers words in a 2-entry {last,data} queue and presents
//               them as a valid/ready stream with a last-word flag.
//               Optional macro SRAM_FIFO_RD_STALL_CNT_EN adds the stall_cnt
//               output, which counts POP cycles spent waiting on an empty fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_fifo_rd_ctrl #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_req,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
`ifdef SRAM_FIFO_RD_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   remaining_q;
  logic               busy_q;
  logic               done_q;

  // Output queue storage: two entries addressed by 1-bit pointers.
  logic [DATA_W-1:0]  q_data_q [2];
  logic               q_last_q [2];
  logic               q_rd_ptr_q;
  logic               q_wr_ptr_q;
  logic [1:0]         q_cnt_q;
  logic [1:0]         q_cnt_d;

  logic               push;
  logic               pop;
  logic               start_acc;

  // A start only counts in IDLE; busy and the DONE cycle both ignore it.
  assign start_acc = (state_q == S_IDLE) && start;

  // Pop only when a word is there, the queue has room and words are still owed.
  assign fifo_rd_req = (state_q == S_POP) && !fifo_empty &&
                       (q_cnt_q < 2'd2) && (remaining_q != '0);

  assign push      = fifo_rd_req;
  assign pop       = out_valid && out_ready;

  assign out_valid = (q_cnt_q != 2'd0);
  assign out_data  = q_data_q[q_rd_ptr_q];
  assign out_last  = q_last_q[q_rd_ptr_q];

  assign busy      = busy_q;
  assign done      = done_q;

  // Next queue occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    q_cnt_d = q_cnt_q;
    case ({push, pop})
      2'b10:   q_cnt_d = q_cnt_q + 2'd1;
      2'b01:   q_cnt_d = q_cnt_q - 2'd1;
      default: q_cnt_d = q_cnt_q;
    endcase
  end

  // Burst sequencing with registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            if (burst_len != '0) begin
              remaining_q <= burst_len;
              busy_q      <= 1'b1;
              state_q     <= S_POP;
            end else begin
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_POP: begin
          if (fifo_rd_req) begin
            remaining_q <= remaining_q - 1'b1;
            state_q     <= S_GAP;
          end
        end
        S_GAP: begin
          // Bubble cycle while the fifo reloads its head word.
          if (remaining_q == '0) begin
            state_q <= S_DRAIN;
          end else begin
            state_q <= S_POP;
          end
        end
        S_DRAIN: begin
          if (q_cnt_q == 2'd0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output queue: write at the tail on a pop strobe, advance head on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_data_q[0] <= '0;
      q_data_q[1] <= '0;
      q_last_q[0] <= 1'b0;
      q_last_q[1] <= 1'b0;
      q_rd_ptr_q  <= 1'b0;
      q_wr_ptr_q  <= 1'b0;
      q_cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        q_data_q[q_wr_ptr_q] <= fifo_rd_data;
        q_last_q[q_wr_ptr_q] <= (remaining_q == {{(LEN_W-1){1'b0}}, 1'b1});
        q_wr_ptr_q           <= ~q_wr_ptr_q;
      end
      if (pop) begin
        q_rd_ptr_q <= ~q_rd_ptr_q;
      end
      q_cnt_q <= q_cnt_d;
    end
  end

`ifdef SRAM_FIFO_RD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  assign stall_cnt = stall_cnt_q;

  // Saturating count of POP cycles blocked by an empty fifo; held after done.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cnt_q <= 16'h0000;
    end else if ((state_q == S_POP) && fifo_empty && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_fifo_rd_ctrl
// Description : Randomized and directed bench for sram_fifo_rd_ctrl with a
//               queue-level reference model of the burst/stream behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  burst_len;
  logic        busy;
  logic        done;
  logic        fifo_empty;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_req;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
`ifdef SRAM_FIFO_RD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  sram_fifo_rd_ctrl #(.DATA_W(32), .LEN_W(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .burst_len    (burst_len),
    .busy         (busy),
    .done         (done),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_req  (fifo_rd_req),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready)
`ifdef SRAM_FIFO_RD_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  // External fifo contents and reference model state.
  logic [31:0] fq [$];
  logic [32:0] mq [$];
  bit          m_busy, m_done, m_gap;
  int          m_left, m_since, m_stall;

  // Event logs taken from the DUT, compared later against literals.
  int          rd_log [$];
  int          done_log [$];
  logic [32:0] acc_log [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_stall = 0;
  int t0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clr_logs();
    rd_log.delete();
    done_log.delete();
    acc_log.delete();
  endtask

  // One clock cycle: present fifo, compare DUT against model, advance model.
  task automatic cycle();
    bit          e_rd, e_valid, acc, new_done, end_busy;
    logic [32:0] head;
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = fifo_empty ? 32'hDEAD_BEEF : fq[0];
    #1;
    e_rd    = m_busy && !m_gap && (m_left > 0) && !fifo_empty && (mq.size() < 2);
    e_valid = (mq.size() > 0);
    head    = e_valid ? mq[0] : 33'd0;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("fifo_rd_req", fifo_rd_req, e_rd);
    chk("out_valid", out_valid, e_valid);
    if (e_valid) begin
      chk("out_data", out_data, head[31:0]);
      chk("out_last", out_last, head[32]);
    end
`ifdef SRAM_FIFO_RD_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    last_stall = stall_cnt;
`endif
    if (fifo_rd_req) rd_log.push_back(cyc);
    if (done) done_log.push_back(cyc);
    if (out_valid && out_ready) acc_log.push_back({out_last, out_data});

    acc      = e_valid && out_ready;
    new_done = 1'b0;
    if (e_rd && fq.size() > 0) void'(fq.pop_front());
    if (rst) begin
      mq.delete();
      m_busy  = 1'b0;
      m_gap   = 1'b0;
      m_left  = 0;
      m_stall = 0;
      m_since = 0;
    end else begin
      // Burst ends once the last pop is two cycles old and the queue is empty.
      end_busy = m_busy && (m_left == 0) && (m_since >= 2) && (mq.size() == 0);
      if (acc) void'(mq.pop_front());
      if (e_rd) mq.push_back({(m_left == 1), fifo_rd_data});
      if (!m_busy && !m_done && start) begin
        m_stall = 0;
        if (burst_len != 0) begin
          m_busy  = 1'b1;
          m_left  = burst_len;
          m_gap   = 1'b0;
          m_since = 2;
        end else begin
          new_done = 1'b1;
        end
      end else if (m_busy) begin
        if (!m_gap && m_left > 0 && fifo_empty && m_stall < 65535) m_stall++;
        if (end_busy) begin
          m_busy   = 1'b0;
          new_done = 1'b1;
        end
        m_gap = e_rd;
        if (e_rd) begin
          m_left--;
          m_since = 1;
        end else if (m_since < 1000) begin
          m_since++;
        end
      end
    end
    m_done = new_done;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int k = 0;
    while (done_log.size() == 0 && k < max_cyc) begin
      cycle();
      k++;
    end
    chk("done_timeout", (done_log.size() > 0), 1);
    cycle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; burst_len = '0; out_ready = 1'b1;
    fifo_empty = 1'b1; fifo_rd_data = '0;
    m_busy = 0; m_done = 0; m_gap = 0; m_left = 0; m_since = 0; m_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    repeat (2) cycle();

    // Three-word burst at full downstream rate
    clr_logs();
    fq.push_back(32'hA1); fq.push_back(32'hA2); fq.push_back(32'hA3);
    t0 = cyc; start = 1'b1; burst_len = 8'd3;
    cycle();
    wait_done(40);
    chk("b3_pops", rd_log.size(), 3);
    chk("b3_pop0", rd_log[0], t0 + 1);
    chk("b3_pop1", rd_log[1], t0 + 3);
    chk("b3_pop2", rd_log[2], t0 + 5);
    chk("b3_w0", acc_log[0], {1'b0, 32'hA1});
    chk("b3_w1", acc_log[1], {1'b0, 32'hA2});
    chk("b3_w2", acc_log[2], {1'b1, 32'hA3});
    chk("b3_done_cyc", done_log[0], t0 + 8);
    chk("b3_busy_after", busy, 1'b0);

    // Zero-length burst
    clr_logs();
    t0 = cyc; start = 1'b1; burst_len = 8'd0;
    cycle();
    repeat (4) cycle();
    chk("b0_done_cyc", done_log[0], t0 + 1);
    chk("b0_done_cnt", done_log.size(), 1);
    chk("b0_no_pop", rd_log.size(), 0);
    chk("b0_no_valid", acc_log.size(), 0);

    // Back-pressure: queue fills at two words
    clr_logs();
    for (int i = 0; i < 5; i++) fq.push_back(32'hB0 + i);
    out_ready = 1'b0;
    start = 1'b1; burst_len = 8'd5;
    cycle();
    repeat (20) cycle();
    chk("bp_pops_held", rd_log.size(), 2);
    out_ready = 1'b1;
    wait_done(60);
    chk("bp_words", acc_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp_word", acc_log[i], {(i == 4), 32'hB0 + i});
    chk("bp_done_cnt", done_log.size(), 1);

    // Empty fifo stall
    clr_logs();
    start = 1'b1; burst_len = 8'd2;
    cycle();
    repeat (10) cycle();
    fq.push_back(32'h11);
    cycle();
`ifdef SRAM_FIFO_RD_STALL_CNT_EN
    chk("stall_at_pop", last_stall, 10);
`endif
    chk("stall_pop1", rd_log.size(), 1);
    repeat (6) cycle();
    chk("stall_wait2", rd_log.size(), 1);
    fq.push_back(32'h22);
    wait_done(20);
    chk("stall_w0", acc_log[0], {1'b0, 32'h11});
    chk("stall_w1", acc_log[1], {1'b1, 32'h22});

    // Reset after the first pop of a four-word burst
    clr_logs();
    for (int i = 0; i < 4; i++) fq.push_back(32'hC0 + i);
    start = 1'b1; burst_len = 8'd4;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    repeat (10) cycle();
    chk("rst_mid_nodone", done_log.size(), 0);
    fq.delete();
    fq.push_back(32'h55);
    clr_logs();
    start = 1'b1; burst_len = 8'd1;
    cycle();
    wait_done(20);
    chk("post_rst_cnt", acc_log.size(), 1);
    chk("post_rst_word", acc_log[0], {1'b1, 32'h55});

    // Second start while busy is ignored
    clr_logs();
    for (int i = 0; i < 3; i++) fq.push_back(32'hD0 + i);
    start = 1'b1; burst_len = 8'd2;
    cycle();
    cycle();
    start = 1'b1; burst_len = 8'd7;
    cycle();
    wait_done(30);
    chk("restart_pops", rd_log.size(), 2);
    chk("restart_words", acc_log.size(), 2);
    fq.delete();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && fq.size() < 8) fq.push_back($urandom);
      start     = ($urandom_range(0, 9) == 0);
      burst_len = 8'($urandom_range(0, 6));
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
